// File: rtl/alu_pkg.sv
// Shared types for the ALU instruction sequencer: opcodes, instruction kinds, FSM states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpInc  = 3'b101,
    OpMova = 3'b110,
    OpMovb = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    KindAlu  = 2'b00,
    KindLdi  = 2'b01,
    KindClrf = 2'b10,
    KindNop  = 2'b11
  } instr_kind_e;

  typedef enum logic [1:0] {
    SeqIdle = 2'b00,
    SeqExec = 2'b01,
    SeqWb   = 2'b10
  } seq_state_e;

  // Every kind except ALU retires in the cycle right after acceptance.
  function automatic logic retires_at_accept(instr_kind_e kind);
    return kind != KindAlu;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return and debug read port of the sequencer.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned nregs = 8
);

  localparam int unsigned aw = $clog2(nregs);

  // Instruction channel
  logic              instr_valid;
  logic              instr_ready;
  instr_kind_e       instr_kind;
  alu_op_e           instr_op;
  logic [aw-1:0]     instr_rd;
  logic [aw-1:0]     instr_ra;
  logic [aw-1:0]     instr_rb;
  logic [width-1:0]  instr_imm;
  logic              instr_flags_en;
  logic              done;

  // ALU side
  logic [width-1:0]  alu_a;
  logic [width-1:0]  alu_b;
  alu_op_e           alu_op;
  logic [width-1:0]  alu_y;
  logic              alu_onz_en;
  logic              alu_rst_pos;

  // Debug register read
  logic [aw-1:0]     dbg_addr;
  logic [width-1:0]  dbg_data;

  // Environment side: instruction source, ALU result and debug address
  modport master (
    output instr_valid, instr_kind, instr_op, instr_rd, instr_ra, instr_rb,
    output instr_imm, instr_flags_en, alu_y, dbg_addr,
    input  instr_ready, done, alu_a, alu_b, alu_op, alu_onz_en, alu_rst_pos, dbg_data
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr_kind, instr_op, instr_rd, instr_ra, instr_rb,
    input  instr_imm, instr_flags_en, alu_y, dbg_addr,
    output instr_ready, done, alu_a, alu_b, alu_op, alu_onz_en, alu_rst_pos, dbg_data
  );

endinterface

// File: rtl/reg_file.sv
// Register file: two combinational operand reads, one debug read, one synchronous write.
module reg_file #(
  parameter int unsigned width = 8,
  parameter int unsigned nregs = 8,
  localparam int unsigned aw = $clog2(nregs)
) (
  input  logic             clk,
  input  logic             rst_neg,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr_a,
  output logic [width-1:0] rdata_a,
  input  logic [aw-1:0]    raddr_b,
  output logic [width-1:0] rdata_b,
  input  logic [aw-1:0]    dbg_addr,
  output logic [width-1:0] dbg_data
);

  logic [width-1:0] mem [nregs];

  // Clear all entries on reset, otherwise single-port write
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      for (int unsigned i = 0; i < nregs; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // nregs is a power of two, so every address is in range
  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer in front of a registered ALU: operand fetch, opcode/flag control and
// result writeback into a small register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned nregs = 8
) (
  input logic            clk,
  input logic            rst_neg,
  alu_sequencer_if.slave bus
);

  localparam int unsigned aw = $clog2(nregs);

  localparam logic [1:0] IDLE = SeqIdle;
  localparam logic [1:0] EXEC = SeqExec;
  localparam logic [1:0] WB   = SeqWb;

  logic [1:0]       state_q, state_d;

  // Operands are captured at acceptance so rd may alias ra/rb freely
  logic [width-1:0] hold_a_q;
  logic [width-1:0] hold_b_q;
  alu_op_e          hold_op_q;
  logic [aw-1:0]    hold_rd_q;
  logic             hold_fe_q;

  logic             clrf_q;
  logic             done_q;

  logic             accept;
  logic             accept_alu;
  logic             accept_ldi;
  logic             accept_clrf;
  logic             accept_quick;

  logic [width-1:0] rdata_a;
  logic [width-1:0] rdata_b;
  logic             rf_we;
  logic [aw-1:0]    rf_waddr;
  logic [width-1:0] rf_wdata;

  assign accept = bus.instr_valid && bus.instr_ready;

  // Decode the accepted instruction kind
  always_comb begin
    accept_alu   = 1'b0;
    accept_ldi   = 1'b0;
    accept_clrf  = 1'b0;
    accept_quick = 1'b0;
    if (accept) begin
      accept_alu   = bus.instr_kind == KindAlu;
      accept_ldi   = bus.instr_kind == KindLdi;
      accept_clrf  = bus.instr_kind == KindClrf;
      accept_quick = retires_at_accept(bus.instr_kind);
    end
  end

  // Next-state: only ALU instructions leave IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_alu) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers feed the ALU through EXEC and WB unchanged
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      hold_a_q  <= '0;
      hold_b_q  <= '0;
      hold_op_q <= OpAdd;
      hold_rd_q <= '0;
      hold_fe_q <= 1'b0;
    end else if (accept_alu) begin
      hold_a_q  <= rdata_a;
      hold_b_q  <= rdata_b;
      hold_op_q <= bus.instr_op;
      hold_rd_q <= bus.instr_rd;
      hold_fe_q <= bus.instr_flags_en;
    end
  end

  // One-cycle pulses: flag clear after CLRF, done on every retirement
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      clrf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      clrf_q <= accept_clrf;
      done_q <= accept_quick || (state_q == WB);
    end
  end

  // Write port: LDI writes at acceptance, ALU results at the end of WB (never both at once)
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.instr_rd;
    rf_wdata = bus.instr_imm;
    if (state_q == WB) begin
      rf_we    = 1'b1;
      rf_waddr = hold_rd_q;
      rf_wdata = bus.alu_y;
    end else if (accept_ldi) begin
      rf_we = 1'b1;
    end
  end

  reg_file #(
    .width (width),
    .nregs (nregs)
  ) u_reg_file (
    .clk      (clk),
    .rst_neg  (rst_neg),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr_a  (bus.instr_ra),
    .rdata_a  (rdata_a),
    .raddr_b  (bus.instr_rb),
    .rdata_b  (rdata_b),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_a       = hold_a_q;
  assign bus.alu_b       = hold_b_q;
  assign bus.alu_op      = hold_op_q;
  // Flag enable only in WB, clear only in an IDLE cycle, so they never overlap
  assign bus.alu_onz_en  = (state_q == WB) && hold_fe_q;
  assign bus.alu_rst_pos = clrf_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: reference registered ALU, cycle-level expectation model, per-cycle
// compare process and directed instruction sequences with literal expectations.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
  localparam int          MAXC  = 2048;

  logic clk = 1'b0;
  logic rst_neg = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.width(W), .nregs(NREGS)) sif ();

  alu_sequencer #(.width(W), .nregs(NREGS)) dut (
    .clk     (clk),
    .rst_neg (rst_neg),
    .bus     (sif)
  );

  // ---------------- reference ALU (registered Y, flags on enable edge) ----------------
  logic [W-1:0] alu_y_q;
  logic [2:0]   onz;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input alu_op_e op);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpInc:   return a + 1'b1;
      OpMova:  return a;
      default: return b;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] y, input alu_op_e op);
    case (op)
      OpAdd:   return (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      OpSub:   return (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      OpInc:   return !a[W-1] && y[W-1];
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      alu_y_q <= '0;
      onz     <= '0;
    end else begin
      alu_y_q <= alu_fn(sif.alu_a, sif.alu_b, sif.alu_op);
      if (sif.alu_rst_pos) onz <= '0;
      else if (sif.alu_onz_en)
        onz <= {alu_ovf(sif.alu_a, sif.alu_b, alu_y_q, sif.alu_op), alu_y_q[W-1], alu_y_q == '0};
    end
  end
  assign sif.alu_y = alu_y_q;

  // ---------------- scoring ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  // Cycle n is the interval after rising edge n; arrays hold what must be seen in that cycle.
  logic [W-1:0] m_rf [NREGS];
  logic [2:0]   m_onz;
  int           cyc = 1;
  int           acc_cnt = 0;
  bit           busy    [MAXC];
  bit           done_e  [MAXC];
  bit           rst_e   [MAXC];
  bit           onzen_e [MAXC];
  bit           opv     [MAXC];
  bit           clr_e   [MAXC];
  bit           wb_v    [MAXC];
  logic [W-1:0] ea      [MAXC];
  logic [W-1:0] eb      [MAXC];
  alu_op_e      eop     [MAXC];
  logic [AW-1:0] wb_addr [MAXC];
  logic [W-1:0] wb_data [MAXC];
  bit           wb_fe   [MAXC];
  logic [2:0]   wb_onz  [MAXC];

  initial begin
    logic [W-1:0] a, b, y;
    int sa, sb, s;
    bit o;
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_onz = '0;
    forever begin
      @(posedge clk or negedge rst_neg);
      if (!rst_neg) begin
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        m_onz = '0;
        for (int k = cyc; k < cyc + 4; k++) begin
          busy[k] = 0; done_e[k] = 0; rst_e[k] = 0; onzen_e[k] = 0;
          opv[k] = 0; clr_e[k] = 0; wb_v[k] = 0;
        end
      end else if (cyc < MAXC - 4) begin
        cyc = cyc + 1;
        if (wb_v[cyc]) begin
          m_rf[wb_addr[cyc]] = wb_data[cyc];
          if (wb_fe[cyc]) m_onz = wb_onz[cyc];
        end
        if (clr_e[cyc]) m_onz = '0;
        if (sif.instr_valid && !busy[cyc-1]) begin
          acc_cnt++;
          case (sif.instr_kind)
            KindAlu: begin
              a = m_rf[sif.instr_ra];
              b = m_rf[sif.instr_rb];
              sa = $signed(a);
              sb = $signed(b);
              s = 0;
              case (sif.instr_op)
                OpAdd:   s = sa + sb;
                OpSub:   s = sa - sb;
                OpInc:   s = sa + 1;
                default: s = 0;
              endcase
              case (sif.instr_op)
                OpAdd, OpSub, OpInc: y = W'(s);
                OpAnd:   y = a & b;
                OpOr:    y = a | b;
                OpXor:   y = a ^ b;
                OpMova:  y = a;
                default: y = b;
              endcase
              o = (s > 127) || (s < -128);
              busy[cyc] = 1; busy[cyc+1] = 1;
              opv[cyc] = 1; opv[cyc+1] = 1;
              ea[cyc] = a; ea[cyc+1] = a;
              eb[cyc] = b; eb[cyc+1] = b;
              eop[cyc] = sif.instr_op; eop[cyc+1] = sif.instr_op;
              onzen_e[cyc+1] = sif.instr_flags_en;
              done_e[cyc+2] = 1;
              wb_v[cyc+2] = 1;
              wb_addr[cyc+2] = sif.instr_rd;
              wb_data[cyc+2] = y;
              wb_fe[cyc+2] = sif.instr_flags_en;
              wb_onz[cyc+2] = {o, y[W-1], y == '0};
            end
            KindLdi: begin
              m_rf[sif.instr_rd] = sif.instr_imm;
              done_e[cyc] = 1;
            end
            KindClrf: begin
              rst_e[cyc] = 1;
              done_e[cyc] = 1;
              clr_e[cyc+1] = 1;
            end
            default: done_e[cyc] = 1;
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit run = 0;
  int dut_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (run && rst_neg) begin
        if (sif.done) dut_done++;
        check("instr_ready", sif.instr_ready, !busy[cyc]);
        check("done",        sif.done,        done_e[cyc]);
        check("alu_onz_en",  sif.alu_onz_en,  onzen_e[cyc]);
        check("alu_rst_pos", sif.alu_rst_pos, rst_e[cyc]);
        check("onz",         onz,             m_onz);
        check("dbg_data",    sif.dbg_data,    m_rf[sif.dbg_addr]);
        if (opv[cyc]) begin
          check("alu_a",  sif.alu_a,       ea[cyc]);
          check("alu_b",  sif.alu_b,       eb[cyc]);
          check("alu_op", 32'(sif.alu_op), 32'(eop[cyc]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    sif.dbg_addr = AW'(sif.dbg_addr + 1);
  endtask

  // Presents one instruction and returns one ns after the edge that accepts it; valid stays high
  task automatic issue(input instr_kind_e k, input alu_op_e op, input int rd, input int ra,
                       input int rb, input logic [W-1:0] imm, input bit fe);
    int start;
    bit got;
    start = acc_cnt;
    got = 0;
    sif.instr_valid    = 1'b1;
    sif.instr_kind     = k;
    sif.instr_op       = op;
    sif.instr_rd       = AW'(rd);
    sif.instr_ra       = AW'(ra);
    sif.instr_rb       = AW'(rb);
    sif.instr_imm      = imm;
    sif.instr_flags_en = fe;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (acc_cnt != start) got = 1;
    end
    check("accept_in_budget", got, 1);
  endtask

  task automatic idle();
    sif.instr_valid = 1'b0;
  endtask

  task automatic peek(input string name, input int addr, input logic [W-1:0] exp);
    sif.dbg_addr = AW'(addr);
    #1;
    check(name, sif.dbg_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc_before;
    sif.instr_valid    = 1'b0;
    sif.instr_kind     = KindNop;
    sif.instr_op       = OpAdd;
    sif.instr_rd       = '0;
    sif.instr_ra       = '0;
    sif.instr_rb       = '0;
    sif.instr_imm      = '0;
    sif.instr_flags_en = 1'b0;
    sif.dbg_addr       = '0;
    rst_neg            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    sif.instr_ready, 1);
    check("rst_done",     sif.done, 0);
    check("rst_alu_a",    sif.alu_a, 0);
    check("rst_alu_b",    sif.alu_b, 0);
    check("rst_alu_op",   32'(sif.alu_op), 0);
    check("rst_onz_en",   sif.alu_onz_en, 0);
    check("rst_rst_pos",  sif.alu_rst_pos, 0);
    peek("rst_rf0", 0, 8'h00);
    peek("rst_rf7", 7, 8'h00);
    #2 rst_neg = 1'b1;
    run = 1;
    tick();

    // LDI r1=7F, LDI r2=01, ADD r3=r1+r2 with flags: signed overflow into 0x80
    issue(KindLdi, OpAdd, 1, 0, 0, 8'h7F, 0);
    issue(KindLdi, OpAdd, 2, 0, 0, 8'h01, 0);
    issue(KindAlu, OpAdd, 3, 1, 2, 8'h00, 1);
    idle();
    tick();
    tick();
    check("add_onz", onz, 3'b110);
    check("model_add_onz", m_onz, 3'b110);
    check("model_rf3", m_rf[3], 8'h80);
    peek("add_rf3", 3, 8'h80);

    // SUB r4=r1-r1 with flags: zero
    issue(KindAlu, OpSub, 4, 1, 1, 8'h00, 1);
    idle();
    tick();
    tick();
    check("sub_onz", onz, 3'b001);
    peek("sub_rf4", 4, 8'h00);

    // INC of 0xFF without flag update wraps to 0, flags untouched
    issue(KindLdi, OpAdd, 1, 0, 0, 8'hFF, 0);
    issue(KindAlu, OpInc, 1, 1, 0, 8'h00, 0);
    idle();
    tick();
    check("inc_onz_en", sif.alu_onz_en, 0);
    tick();
    check("inc_onz_kept", onz, 3'b001);
    peek("inc_rf1", 1, 8'h00);

    // CLRF: one-cycle clear pulse with done in the same cycle
    issue(KindClrf, OpAdd, 0, 0, 0, 8'h00, 0);
    idle();
    check("clrf_pulse", sif.alu_rst_pos, 1);
    check("clrf_done", sif.done, 1);
    tick();
    check("clrf_pulse_end", sif.alu_rst_pos, 0);
    check("clrf_onz", onz, 3'b000);

    issue(KindNop, OpAdd, 0, 0, 0, 8'h00, 0);
    idle();
    tick();

    // Two ALU instructions with valid held high through the busy cycles
    acc_before = acc_cnt;
    issue(KindAlu, OpXor, 0, 1, 2, 8'h00, 1);
    check("held_ready_low0", sif.instr_ready, 0);
    issue(KindAlu, OpOr, 6, 0, 2, 8'h00, 0);
    idle();
    tick();
    tick();
    check("held_accepts", acc_cnt - acc_before, 2);
    peek("xor_rf0", 0, 8'h01);
    peek("or_rf6", 6, 8'h01);

    // Reset during EXEC aborts the ADD
    issue(KindAlu, OpAdd, 5, 2, 2, 8'h00, 1);
    idle();
    #1 rst_neg = 1'b0;
    #1;
    check("abort_ready", sif.instr_ready, 1);
    check("abort_done", sif.done, 0);
    @(posedge clk);
    #3 rst_neg = 1'b1;
    tick();
    peek("abort_rf5", 5, 8'h00);
    peek("abort_rf2", 2, 8'h00);
    issue(KindLdi, OpAdd, 5, 0, 0, 8'h33, 0);
    idle();
    peek("ldi_rf5", 5, 8'h33);
    tick();

    // LDI then immediate MOVA reads the freshly written register
    issue(KindLdi, OpAdd, 6, 0, 0, 8'hAA, 0);
    issue(KindAlu, OpMova, 7, 6, 0, 8'h00, 0);
    idle();
    check("mova_a_exec", sif.alu_a, 8'hAA);
    tick();
    check("mova_a_wb", sif.alu_a, 8'hAA);
    tick();
    tick();
    peek("mova_rf7", 7, 8'hAA);
    check("model_rf7", m_rf[7], 8'hAA);

    // 14 acceptances, one aborted by reset
    check("model_accepts", acc_cnt, 14);
    check("done_count", dut_done, 13);

    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction sequencer that sits directly upstream of the registered ALU and drives its operand, opcode, flag-enable and flag-clear inputs. It accepts one instruction at a time over a valid/ready handshake, holds a small register file, reads operands into the ALU, and writes the ALU result back. It also clears or updates the ALU flags on request. Its ALU-facing ports match the ALU contract: `Y` is registered one cycle after `A`/`B`/`op`, and `ONZ` is captured on an `ONZ_en` edge from the current `Y`, `A` and `B`.

## Interface
- `width`, 8: data width; equals the ALU `width`.
- `nregs`, 8: register-file entries; power of two; `aw = $clog2(nregs)`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_neg`  in  1  asynchronous active-low reset, shared with the ALU.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept; high only in `IDLE`.
- `instr_kind`  in  2  `00` ALU, `01` LDI, `10` CLRF, `11` NOP.
- `instr_op`  in  3  ALU opcode: `000` ADD, `001` SUB, `010` AND, `011` OR, `100` XOR, `101` INC, `110` MOVA, `111` MOVB.
- `instr_rd`, `instr_ra`, `instr_rb`  in  aw each  destination and source registers.
- `instr_imm`  in  width  LDI immediate.
- `instr_flags_en`  in  1  ALU kind only: update ONZ at writeback.
- `alu_a`, `alu_b`  out  width  ALU operands.
- `alu_op`  out  3  ALU opcode.
- `alu_y`  in  width  ALU registered result.
- `alu_onz_en`  out  1  ALU flag-register enable.
- `alu_rst_pos`  out  1  ALU synchronous flag clear.
- `done`  out  1  one-cycle pulse on instruction retirement.
- `dbg_addr`  in  aw  register-file debug read address.
- `dbg_data`  out  width  combinational read of `rf[dbg_addr]`.

## Operation
- States: `IDLE`, `EXEC`, `WB`.
- Accept: `instr_valid && instr_ready` at a rising edge. All decisions below are taken at that edge.
- ALU kind:
  - Latch `rf[ra]`, `rf[rb]`, `op`, `rd` and `flags_en` into holding registers. Go to `EXEC`.
  - `EXEC`: drive `alu_a`, `alu_b` and `alu_op` from the holding registers. The ALU captures `Y` at the end of the cycle. Go to `WB`.
  - `WB`: keep `alu_a`/`alu_b`/`alu_op` unchanged, because overflow detection needs them. Drive `alu_onz_en = flags_en`. At the end of the cycle, write `rf[rd] <= alu_y` and pulse `done`. Go to `IDLE`.
- LDI: write `rf[rd] <= instr_imm` at the accept edge. `done` is high in the next cycle. Stay in `IDLE`.
- CLRF: `alu_rst_pos` is high for exactly the cycle after acceptance. `done` is high in that same cycle. Stay in `IDLE`.
- NOP: `done` is high in the next cycle. No other effect.
- Operands are sampled at acceptance, so `rd == ra` or `rd == rb` is always safe.
- An LDI followed immediately by an ALU read of the same register sees the new value.
- Arithmetic is performed entirely by the ALU. The sequencer never modifies data; writeback is the full `width` bits with no extension.
- `alu_onz_en` and `alu_rst_pos` are never high in the same cycle.

## Timing
- Reset (asynchronous, `rst_neg` low):
  - State goes to `IDLE`; all `rf` entries and holding registers are cleared to 0.
  - `instr_ready` is 1.
  - `alu_a`, `alu_b`, `alu_op`, `alu_onz_en`, `alu_rst_pos` and `done` are all 0.
- Reset mid-`EXEC`/`WB` aborts the instruction: no writeback, no `done`.
- ALU instruction: accepted at edge 0; `Y` captured at edge 1; `rf` and ONZ updated at edge 2; `done` is high between edges 2 and 3. `instr_ready` is low between edges 0 and 2.
- Throughput: one ALU instruction per 3 cycles; LDI, CLRF and NOP one per cycle.
- While `instr_ready` is low, `instr_valid` may be held with any values. Nothing is sampled.
- `done` never pulses twice for one instruction.

## Structure
- Package `alu_pkg`: `alu_op_e` (8 opcodes above), `instr_kind_e`, `seq_state_e`, and `ALU_OP_W = 3`.
- Sub-module `reg_file`:
  - Parameters `width`, `nregs`.
  - 2 combinational read ports for `ra`/`rb`, plus the debug port.
  - 1 synchronous write port.
  - Asynchronous active-low clear.
- Bench instantiates `alu_sequencer` together with the ALU.

## Test plan
- LDI r1=0x7F, LDI r2=0x01, ADD r3=r1+r2 with flags_en -> `rf[3]=0x80`, ONZ=`110` after the WB edge, `done` once per instruction.
- SUB r4=r1-r1 with flags_en -> `rf[4]=0x00`, ONZ=`001`. Then CLRF -> `alu_rst_pos` high 1 cycle, ONZ=`000`.
- INC r1=r1+1 with r1=0xFF and flags_en=0 -> `rf[1]=0x00`, ONZ unchanged, `alu_onz_en` stays 0.
- `instr_valid` held high across an ALU instruction -> `instr_ready` low 2 cycles, exactly one acceptance per instruction, no lost or duplicated instruction.
- `rst_neg` asserted during `EXEC` of ADD r5 -> `rf[5]=0`, no `done`, `instr_ready=1` immediately. Later LDI r5=0x33 -> `dbg_data=0x33`.
- Back-to-back LDI r6=0xAA, then MOVA r7=r6 -> `rf[7]=0xAA`; `alu_a` stable at 0xAA through `EXEC` and `WB`.
